// File: rtl/bcd_7seg_scanner_if.sv
// Bus bundle between the BCD source / display consumer and bcd_7seg_scanner.
//   master : drives bcd, load, blank_lz; observes seg, an, valid, frame_done
//   slave  : the scanner itself
// Signals:
//   bcd        packed BCD value, digit 0 in bits [3:0]
//   load       capture request (level, edge-detected by the scanner)
//   blank_lz   1 = blank leading zeros
//   seg        {g,f,e,d,c,b,a}, active-low
//   an         digit enables, active-low
//   valid      a value has been captured since reset
//   frame_done one-cycle pulse at the start of each scan frame
interface bcd_7seg_scanner_if #(
  parameter int DIGITS = 6
);
  logic [DIGITS*4-1:0] bcd;
  logic                load;
  logic                blank_lz;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                valid;
  logic                frame_done;

  modport master (
    output bcd, load, blank_lz,
    input  seg, an, valid, frame_done
  );

  modport slave (
    input  bcd, load, blank_lz,
    output seg, an, valid, frame_done
  );
endinterface

// File: rtl/bcd_7seg_scanner.sv
// Multiplexed seven-segment driver. Captures a packed BCD value on the rising
// edge of load into a shadow register and scans its digits onto one shared
// active-low segment bus, one digit per REFRESH_DIV clocks.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    bcd_7seg_scanner_if.slave (bcd, load, blank_lz in;
//          seg, an, valid, frame_done out, all registered)
module bcd_7seg_scanner #(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_7seg_scanner_if.slave     bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  // Active-low decode; nibbles above 9 show a lone dash (segment g).
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic                load_d_q,     load_d_d;
  logic [DIGITS*4-1:0] shadow_q,     shadow_d;
  logic                valid_q,      valid_d;
  logic [PRE_W-1:0]    presc_q,      presc_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic                frame_done_q, frame_done_d;
  logic [6:0]          seg_q,        seg_d;
  logic [DIGITS-1:0]   an_q,         an_d;

  logic       rise;
  logic       tc;
  logic       last_digit;
  logic [3:0] cur_digit;
  logic       lead_zero;
  logic       cur_blank;

  always_comb begin
    // capture on the rising edge of load only
    rise     = bus.load & ~load_d_q;
    load_d_d = bus.load;
    shadow_d = rise ? bus.bcd : shadow_q;
    valid_d  = valid_q | rise;

    // prescaler and digit index
    tc           = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d      = tc ? '0 : presc_q + 1'b1;
    last_digit   = (idx_q == IDX_W'(DIGITS - 1));
    idx_d        = tc ? (last_digit ? '0 : idx_q + 1'b1) : idx_q;
    frame_done_d = tc & last_digit;

    // Walk from the most significant digit down; lead_zero stays 1 while
    // every digit from the top down to j is zero.
    cur_digit = '0;
    cur_blank = 1'b0;
    lead_zero = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      lead_zero = lead_zero & (shadow_q[4*j +: 4] == 4'd0);
      if (idx_q == IDX_W'(j)) begin
        cur_digit = shadow_q[4*j +: 4];
        cur_blank = lead_zero & (j != 0);
      end
    end

    // output stage, registered from the current index and shadow
    if (!valid_q || (bus.blank_lz && cur_blank)) begin
      seg_d = 7'h7F;
      an_d  = '1;
    end else begin
      seg_d = seg7_decode(cur_digit);
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_d_q     <= 1'b0;
      shadow_q     <= '0;
      valid_q      <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
    end else begin
      load_d_q     <= load_d_d;
      shadow_q     <= shadow_d;
      valid_q      <= valid_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Bench for bcd_7seg_scanner with DIGITS=6, REFRESH_DIV=4: table of captured
// values with expected per-digit segments, scoreboard of expected frames, and
// hand-written sequences for reset, held load and mid-frame reset.
module tb_bcd_7seg_scanner;

  localparam int DIGITS = 6;
  localparam int RDIV   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_7seg_scanner_if #(.DIGITS(DIGITS)) dif ();

  bcd_7seg_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [5:0] an;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [23:0]      bcd;
    logic             blz;
    logic [5:0][6:0]  segs;   // expected seg per digit, 7F = dark
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // One frame's worth of expected samples, 4 per digit, pulse on the last.
  task automatic push_frame(input logic [5:0][6:0] segs);
    exp_t e;
    for (int i = 0; i < DIGITS; i++) begin
      for (int k = 0; k < RDIV; k++) begin
        e.seg = segs[i];
        e.an  = (segs[i] == 7'h7F) ? 6'h3F : ~(6'd1 << i);
        e.fd  = (i == DIGITS - 1) && (k == RDIV - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain_frame(input string name);
    int   n = 0;
    exp_t e;
    while (dif.frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dif.frame_done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s: frame_done timeout, actual 0 required 1", name);
      sb.delete();
      return;
    end
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({dif.seg, dif.an, dif.frame_done} !== {e.seg, e.an, e.fd}) begin
        fails++;
        $display("FAIL %s sample %0d: actual seg=%b an=%b fd=%b required seg=%b an=%b fd=%b",
                 name, n, dif.seg, dif.an, dif.frame_done, e.seg, e.an, e.fd);
      end
      n++;
    end
  endtask

  task automatic load_pulse(input logic [23:0] v, input logic blz);
    dif.bcd      = v;
    dif.blank_lz = blz;
    dif.load     = 1'b1;
    @(negedge clk);
    dif.load     = 1'b0;
  endtask

  initial begin
    //               bcd         blz  d5     d4     d3     d2     d1     d0
    vecs[0] = '{24'h000200, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40}};
    vecs[1] = '{24'h000200, 1'b0, {7'h40, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40}};
    vecs[2] = '{24'h00000A, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F}};
    vecs[3] = '{24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{24'h123456, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[5] = '{24'h789F00, 1'b0, {7'h78, 7'h00, 7'h10, 7'h3F, 7'h40, 7'h40}};
    vecs[6] = '{24'h0B0001, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h79}};
    vecs[7] = '{24'h000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

    reset        = 1'b0;
    dif.bcd      = '0;
    dif.load     = 1'b0;
    dif.blank_lz = 1'b1;

    // reset state, then two dark scan periods with no load
    repeat (3) @(negedge clk);
    check("reset_seg",   32'(dif.seg),        32'h7F);
    check("reset_an",    32'(dif.an),         32'h3F);
    check("reset_valid", 32'(dif.valid),      32'h0);
    check("reset_fd",    32'(dif.frame_done), 32'h0);
    reset = 1'b1;
    for (int c = 0; c < 2 * DIGITS * RDIV; c++) begin
      @(negedge clk);
      check("dark_idle", {dif.valid, dif.seg, dif.an}, {1'b0, 7'h7F, 6'h3F});
    end

    // table of captured values
    for (int v = 0; v < 8; v++) begin
      load_pulse(vecs[v].bcd, vecs[v].blz);
      check("valid_after_load", 32'(dif.valid), 32'h1);
      push_frame(vecs[v].segs);
      drain_frame($sformatf("vec%0d", v));
    end

    // held load: 990 captured once, later bcd changes ignored
    dif.bcd      = 24'h000990;
    dif.blank_lz = 1'b1;
    dif.load     = 1'b1;
    @(negedge clk);
    dif.bcd      = 24'h000064;
    push_frame({7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10, 7'h40});
    drain_frame("held_load_990");
    dif.load = 1'b0;
    @(negedge clk);
    load_pulse(24'h000064, 1'b1);
    check("valid_recapture", 32'(dif.valid), 32'h1);
    push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h19});
    drain_frame("recapture_64");

    // reset during digit3: dark immediately, scan restarts at digit0
    load_pulse(24'h123456, 1'b0);
    push_frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    drain_frame("pre_reset_frame");
    repeat (14) @(negedge clk);
    check("mid_digit3_an", 32'(dif.an), 32'h37);
    #2 reset = 1'b0;
    #1;
    check("async_reset_dark", {dif.valid, dif.seg, dif.an, dif.frame_done},
          {1'b0, 7'h7F, 6'h3F, 1'b0});
    @(negedge clk);
    reset    = 1'b1;
    dif.load = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
    check("restart_valid",  32'(dif.valid), 32'h1);
    check("restart_dark",   32'(dif.an),    32'h3F);
    @(negedge clk);
    check("restart_digit0", {dif.seg, dif.an}, {7'h02, 6'h3E});
    repeat (3) @(negedge clk);
    check("restart_digit1", {dif.seg, dif.an}, {7'h12, 6'h3D});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
